// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - microwave countdown sequencer: keypad preset, load, 1 Hz enable, magnetron gating
// Drives the external BCD down-counter chain; the time count itself lives in the chain.
module timer_ctrl #(
  parameter int TICK_DIV    = 100,
  parameter int DONE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  input  logic       zero_all,
  output logic [3:0] data_min,
  output logic [3:0] data_tens,
  output logic [3:0] data_ones,
  output logic       loadn,
  output logic       cnt_en,
  output logic       timer_clrn,
  output logic       mag_on,
  output logic       done,
  output logic       key_err
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DONE_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DONE_LAST  = DW'(DONE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_LOAD, S_RUN, S_PAUSE, S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [PW-1:0] presc, presc_nx;
  logic [DW-1:0] dcnt, dcnt_nx;
  logic [3:0]    min_nx, tens_nx, ones_nx;
  logic          loadn_nx, cnt_en_nx, key_err_nx;
  logic          clr_n, clr_n_nx;
  logic          tick, preset_nz, key_ok;

  assign tick      = (presc == PRESC_LAST);
  assign preset_nz = |{data_min, data_tens, data_ones};
  // ones shifts into the seconds-tens slot next, so it must already be a legal 0..5
  assign key_ok    = (key_digit <= 4'd9) && (data_ones <= 4'd5);

  // Chain clear follows the external reset as well as the internal cancel pulse
  assign timer_clrn = clrn & clr_n;

  always_comb begin
    state_nx   = state;
    presc_nx   = presc;
    dcnt_nx    = dcnt;
    min_nx     = data_min;
    tens_nx    = data_tens;
    ones_nx    = data_ones;
    loadn_nx   = 1'b1;
    cnt_en_nx  = 1'b0;
    key_err_nx = 1'b0;
    clr_n_nx   = 1'b1;

    case (state)
      S_IDLE, S_ENTRY: begin
        if (start && preset_nz && door_closed) begin
          state_nx = S_LOAD;
        end else if (key_valid) begin
          if (key_ok) begin
            min_nx   = data_tens;
            tens_nx  = data_ones;
            ones_nx  = key_digit;
            state_nx = S_ENTRY;
          end else begin
            key_err_nx = 1'b1;
          end
        end
      end
      S_LOAD: begin
        state_nx = S_RUN;
        presc_nx = '0;
      end
      S_RUN: begin
        // stop/door win over a coincident tick; the tick is simply dropped
        if (stop || !door_closed) begin
          state_nx = S_PAUSE;
        end else if (tick) begin
          presc_nx = '0;
          if (zero_all) begin
            state_nx = S_DONE;
            dcnt_nx  = '0;
          end else begin
            cnt_en_nx = 1'b1;
          end
        end else begin
          presc_nx = presc + 1'b1;
        end
      end
      S_PAUSE: begin
        if (stop) begin
          state_nx = S_IDLE;
          min_nx   = '0;
          tens_nx  = '0;
          ones_nx  = '0;
          clr_n_nx = 1'b0;
        end else if (start && door_closed) begin
          state_nx = S_RUN;
          presc_nx = '0;
        end
      end
      S_DONE: begin
        if (stop || dcnt == DONE_LAST) begin
          state_nx = S_IDLE;
          min_nx   = '0;
          tens_nx  = '0;
          ones_nx  = '0;
        end else begin
          dcnt_nx = dcnt + 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    if (state_nx == S_LOAD) loadn_nx = 1'b0;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= S_IDLE;
      presc     <= '0;
      dcnt      <= '0;
      data_min  <= '0;
      data_tens <= '0;
      data_ones <= '0;
      loadn     <= 1'b1;
      cnt_en    <= 1'b0;
      mag_on    <= 1'b0;
      done      <= 1'b0;
      key_err   <= 1'b0;
      clr_n     <= 1'b1;
    end else begin
      state     <= state_nx;
      presc     <= presc_nx;
      dcnt      <= dcnt_nx;
      data_min  <= min_nx;
      data_tens <= tens_nx;
      data_ones <= ones_nx;
      loadn     <= loadn_nx;
      cnt_en    <= cnt_en_nx;
      mag_on    <= (state_nx == S_RUN);
      done      <= (state_nx == S_DONE);
      key_err   <= key_err_nx;
      clr_n     <= clr_n_nx;
    end
  end

endmodule
